// File: rtl/y_quantizer.sv
// Parallel JPEG luma quantizer: 64 coefficients per block, reciprocal multiply with round-half-up.
// Q/out_enable appear 3 edges after the capture edge; a new block can be accepted every cycle.
module y_quantizer (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic signed [10:0] Z [0:7][0:7],
    output logic signed [10:0] Q [0:7][0:7],
    output logic               out_enable
);

    localparam int QT [0:7][0:7] = '{
        '{16, 11, 10, 16,  24,  40,  51,  61},
        '{12, 12, 14, 19,  26,  58,  60,  55},
        '{14, 13, 16, 24,  40,  57,  69,  56},
        '{14, 17, 22, 29,  51,  87,  80,  62},
        '{18, 22, 37, 56,  68, 109, 103,  77},
        '{24, 35, 55, 64,  81, 104, 113,  92},
        '{49, 64, 78, 87, 103, 121, 120, 101},
        '{72, 92, 95, 98, 112, 100, 103,  99}
    };

    // Reciprocal is a constant per position, so each multiply collapses to shifts/adds.
    function automatic logic signed [23:0] scale(input logic signed [10:0] z, input int i, input int j);
        logic signed [23:0] zx;
        logic signed [23:0] rx;
        zx = z;
        rx = 24'(4096 / QT[i][j]);
        return zx * rx;
    endfunction

    logic               cap_vld;
    logic               mul_vld;
    logic               shf_vld;
    logic signed [10:0] z_r   [0:7][0:7];
    logic signed [23:0] p_r   [0:7][0:7];
    logic signed [10:0] s_r   [0:7][0:7];
    logic        [0:7][0:7] rnd_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_vld    <= 1'b0;
            mul_vld    <= 1'b0;
            shf_vld    <= 1'b0;
            out_enable <= 1'b0;
            rnd_r      <= '0;
            for (int i = 0; i < 8; i++) begin
                for (int j = 0; j < 8; j++) begin
                    z_r[i][j] <= '0;
                    p_r[i][j] <= '0;
                    s_r[i][j] <= '0;
                    Q[i][j]   <= '0;
                end
            end
        end else begin
            cap_vld    <= enable;
            mul_vld    <= cap_vld;
            shf_vld    <= mul_vld;
            out_enable <= shf_vld;
            for (int i = 0; i < 8; i++) begin
                for (int j = 0; j < 8; j++) begin
                    if (enable)
                        z_r[i][j] <= Z[i][j];
                    if (cap_vld)
                        p_r[i][j] <= scale(z_r[i][j], i, j);
                    // Bits 22:12 are P>>>12 truncated to 11 bits; bit 11 is the half-LSB for rounding.
                    if (mul_vld) begin
                        s_r[i][j]   <= p_r[i][j][22:12];
                        rnd_r[i][j] <= p_r[i][j][11];
                    end
                    if (shf_vld)
                        Q[i][j] <= s_r[i][j] + {10'b0, rnd_r[i][j]};
                end
            end
        end
    end

endmodule

// File: tb/tb_y_quantizer.sv
// Directed bench for y_quantizer: hand-computed corner values plus a per-entry reference model.
module tb_y_quantizer;

    logic               clk;
    logic               rst;
    logic               enable;
    logic signed [10:0] z_in  [0:7][0:7];
    logic signed [10:0] q_out [0:7][0:7];
    logic               out_enable;

    int checks   = 0;
    int failures = 0;

    int qt [0:7][0:7] = '{
        '{16, 11, 10, 16,  24,  40,  51,  61},
        '{12, 12, 14, 19,  26,  58,  60,  55},
        '{14, 13, 16, 24,  40,  57,  69,  56},
        '{14, 17, 22, 29,  51,  87,  80,  62},
        '{18, 22, 37, 56,  68, 109, 103,  77},
        '{24, 35, 55, 64,  81, 104, 113,  92},
        '{49, 64, 78, 87, 103, 121, 120, 101},
        '{72, 92, 95, 98, 112, 100, 103,  99}
    };

    y_quantizer dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .Z          (z_in),
        .Q          (q_out),
        .out_enable (out_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // 0: all 1023, 1: ramp, 2: checkerboard, 3: all -1024, 4: scattered values
    function automatic int zval(input int pat, input int i, input int j);
        case (pat)
            0:       return 1023;
            1:       return 8 * i + j;
            2:       return ((i + j) % 2 == 0) ? 1023 : -1024;
            3:       return -1024;
            default: return ((i * 131 + j * 57) % 2048) - 1024;
        endcase
    endfunction

    function automatic int exp_q(input int pat, input int i, input int j);
        int p;
        p = zval(pat, i, j) * (4096 / qt[i][j]);
        return (p >>> 12) + ((p >>> 11) & 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_z(input int pat);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                z_in[i][j] = 11'(zval(pat, i, j));
    endtask

    task automatic check_block(input int pat, input string tag);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                check($sformatf("%s_q[%0d][%0d]", tag, i, j), int'(q_out[i][j]), exp_q(pat, i, j));
    endtask

    // One enable, then Z is scrambled so a late capture would show up in Q.
    task automatic run_block(input int pat, input string tag);
        set_z(pat);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        set_z(3);
        tick();
        check({tag, "_oe_n1"}, int'(out_enable), 0);
        tick();
        check({tag, "_oe_n2"}, int'(out_enable), 0);
        tick();
        check({tag, "_oe_n3"}, int'(out_enable), 1);
        check_block(pat, tag);
        tick();
        check({tag, "_oe_n4"}, int'(out_enable), 0);
        check_block(pat, {tag, "_hold"});
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        set_z(3);
        #2;
        check("rst_oe", int'(out_enable), 0);
        check("rst_q00", int'(q_out[0][0]), 0);
        check("rst_q77", int'(q_out[7][7]), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        run_block(0, "max");
        check("max_q00", int'(q_out[0][0]), 64);
        check("max_q01", int'(q_out[0][1]), 93);
        check("max_q02", int'(q_out[0][2]), 102);
        check("max_q77", int'(q_out[7][7]), 10);

        run_block(1, "ramp");
        check("ramp_q00", int'(q_out[0][0]), 0);
        check("ramp_q01", int'(q_out[0][1]), 0);
        check("ramp_q77", int'(q_out[7][7]), 1);

        run_block(2, "chk");
        check("chk_q00", int'(q_out[0][0]), 64);
        check("chk_q01", int'(q_out[0][1]), -93);
        check("chk_q10", int'(q_out[1][0]), -85);
        check("chk_q11", int'(q_out[1][1]), 85);

        run_block(3, "min");
        check("min_q00", int'(q_out[0][0]), -64);

        // Back-to-back: three blocks on consecutive edges
        set_z(0);
        enable = 1'b1;
        tick();
        set_z(4);
        tick();
        set_z(2);
        tick();
        enable = 1'b0;
        set_z(3);
        tick();
        check("b2b_oe0", int'(out_enable), 1);
        check_block(0, "b2b0");
        tick();
        check("b2b_oe1", int'(out_enable), 1);
        check_block(4, "b2b1");
        tick();
        check("b2b_oe2", int'(out_enable), 1);
        check_block(2, "b2b2");
        tick();
        check("b2b_oe_end", int'(out_enable), 0);

        // Reset one cycle after enable: in-flight block must vanish
        set_z(1);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("arst_oe", int'(out_enable), 0);
        check("arst_q00", int'(q_out[0][0]), 0);
        check("arst_q02", int'(q_out[0][2]), 0);
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("arst_late_oe%0d", c), int'(out_enable), 0);
        end
        check("arst_q_after", int'(q_out[0][0]), 0);

        run_block(4, "post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
